gps_code_sched: RTL and testbench

Round-robin scheduler that shares the single GPS code generator (C/A, P, L code core) among up to NUM_SV configured satellite-vehicle slots. It selects the next enabled slot, programs the core's SV number, and runs a four-phase generate handshake with it. It captures each finished code set with its SV tag into a small result FIFO that a downstream consumer drains with valid/ready. It sits between the Wishbone register file and the gps core, replacing direct software control of genNext.

---
 rtl/gps_code_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_gps_code_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_code_sched.sv
// gps_code_sched: round-robin sharing of one GPS code core across NUM_SV slots, results queued in a DEPTH-entry FIFO.
// Latency: IDLE->SELECT 1 cycle, gen_next_o rises the cycle after SELECT, slot period N+4 for an N-cycle core.
// Backpressure: a full FIFO (pre-pop count) holds the FSM in CAPTURE; GPS_SCHED_TIMEOUT_EN builds the phase timeout.
module gps_code_sched #(
    parameter int NUM_SV  = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                run_i,
    input  logic [NUM_SV-1:0]   slot_en_i,
    input  logic [6*NUM_SV-1:0] sv_table_i,
    input  logic                err_clr_i,
    output logic [5:0]          sv_num_o,
    output logic                gen_next_o,
    input  logic                codes_valid_i,
    input  logic [12:0]         ca_code_i,
    input  logic [127:0]        p_code_i,
    input  logic [127:0]        l_code_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [5:0]          out_sv_o,
    output logic [12:0]         out_ca_o,
    output logic [127:0]        out_p_o,
    output logic [127:0]        out_l_o,
    output logic                busy_o,
    output logic                err_o
);
    localparam int SLOT_W = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;

    if (NUM_SV < 1 || NUM_SV > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
        $error("gps_code_sched: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, SELECT, START, RUN, CAPTURE} state_t;

    typedef struct packed {
        logic [5:0]   sv;
        logic [12:0]  ca;
        logic [127:0] p;
        logic [127:0] l;
    } entry_t;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_last_slot;
    logic [5:0]          r_sv_num;
    logic                r_gen_next;
    logic                r_busy;

    entry_t              r_fifo_dat [DEPTH];
    logic [DEPTH-1:0]    r_fifo_vld;
    entry_t              w_fifo_dat [DEPTH];
    logic [DEPTH-1:0]    w_fifo_vld;
    entry_t              w_push_dat;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_sel_found;
    logic [SLOT_W-1:0]   w_sel_idx;
    logic                w_abort;

    // First enabled slot after the last one served, wrapping.
    always_comb begin
        int j;
        j           = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 1; k <= NUM_SV; k++) begin
            j = int'(r_last_slot) + k;
            if (j >= NUM_SV) begin
                j = j - NUM_SV;
            end
            if (!w_sel_found && slot_en_i[j]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = SLOT_W'(j);
            end
        end
    end

    // Shift-register FIFO: entry 0 is always the head so outputs come straight from flops.
    assign w_full     = r_fifo_vld[DEPTH-1];
    assign w_pop      = r_fifo_vld[0] & out_ready_i;
    assign w_push     = (r_state == CAPTURE) && !w_full;
    assign w_push_dat = {r_sv_num, ca_code_i, p_code_i, l_code_i};

    always_comb begin
        logic done;
        done       = 1'b0;
        w_fifo_vld = r_fifo_vld;
        w_fifo_dat = r_fifo_dat;
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_fifo_vld[i] = r_fifo_vld[i+1];
                w_fifo_dat[i] = r_fifo_dat[i+1];
            end
            w_fifo_vld[DEPTH-1] = 1'b0;
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!done && !w_fifo_vld[i]) begin
                    w_fifo_vld[i] = 1'b1;
                    w_fifo_dat[i] = w_push_dat;
                    done          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_fifo_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_dat[i] <= '0;
            end
        end else begin
            r_fifo_vld <= w_fifo_vld;
            r_fifo_dat <= w_fifo_dat;
        end
    end

`ifdef GPS_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_abort   = w_expired && (((r_state == START) && codes_valid_i) ||
                                     ((r_state == RUN) && !codes_valid_i));

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_cnt <= '0;
        end else if ((r_state == SELECT && w_sel_found) || (r_state == START && !codes_valid_i)) begin
            r_cnt <= '0;
        end else if ((r_state == START || r_state == RUN) && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A clear in the same cycle as an abort wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_err <= 1'b0;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_abort = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state     <= IDLE;
            r_last_slot <= SLOT_W'(NUM_SV - 1);
            r_sv_num    <= '0;
            r_gen_next  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run_i && |slot_en_i) begin
                        r_state <= SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (w_sel_found) begin
                        r_state     <= START;
                        r_sv_num    <= sv_table_i[6*w_sel_idx +: 6];
                        r_last_slot <= w_sel_idx;
                        r_gen_next  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                START: begin
                    if (!codes_valid_i) begin
                        r_state    <= RUN;
                        r_gen_next <= 1'b0;
                    end else if (w_abort) begin
                        r_state    <= run_i ? SELECT : IDLE;
                        r_busy     <= run_i;
                        r_gen_next <= 1'b0;
                    end
                end
                RUN: begin
                    if (codes_valid_i) begin
                        r_state <= CAPTURE;
                    end else if (w_abort) begin
                        r_state <= run_i ? SELECT : IDLE;
                        r_busy  <= run_i;
                    end
                end
                CAPTURE: begin
                    // The core holds its codes while gen_next_o is low, so waiting here is lossless.
                    if (!w_full) begin
                        r_state <= run_i ? SELECT : IDLE;
                        r_busy  <= run_i;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_gen_next <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign sv_num_o    = r_sv_num;
    assign gen_next_o  = r_gen_next;
    assign busy_o      = r_busy;
    assign out_valid_o = r_fifo_vld[0];
    assign out_sv_o    = r_fifo_dat[0].sv;
    assign out_ca_o    = r_fifo_dat[0].ca;
    assign out_p_o     = r_fifo_dat[0].p;
    assign out_l_o     = r_fifo_dat[0].l;

endmodule

// File: tb/tb_gps_code_sched.sv
// Bench for gps_code_sched: behavioural code core, head monitor, and a slot-order reference model.
module tb_gps_code_sched;
    localparam int NUM_SV  = 4;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [5:0]   sv;
        logic [12:0]  ca;
        logic [127:0] p;
        logic [127:0] l;
    } ent_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                run = 1'b0;
    logic [NUM_SV-1:0]   slot_en = '0;
    logic [6*NUM_SV-1:0] sv_table = '0;
    logic                err_clr = 1'b0;
    logic [5:0]          sv_num;
    logic                gen_next;
    logic                codes_valid = 1'b1;
    logic [12:0]         ca_code = '0;
    logic [127:0]        p_code = '0;
    logic [127:0]        l_code = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [5:0]          out_sv;
    logic [12:0]         out_ca;
    logic [127:0]        out_p;
    logic [127:0]        out_l;
    logic                busy;
    logic                err;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  tbl [NUM_SV];
    logic [31:0] salt = '0;
    int          gen_cycles = 4;
    bit          hang = 1'b0;
    ent_t        got [$];

    gps_code_sched #(.NUM_SV(NUM_SV), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .run_i(run), .slot_en_i(slot_en),
        .sv_table_i(sv_table), .err_clr_i(err_clr), .sv_num_o(sv_num), .gen_next_o(gen_next),
        .codes_valid_i(codes_valid), .ca_code_i(ca_code), .p_code_i(p_code), .l_code_i(l_code),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sv_o(out_sv), .out_ca_o(out_ca),
        .out_p_o(out_p), .out_l_o(out_l), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Codes the model core produces for a given SV under the current salt.
    function automatic ent_t mk(input logic [5:0] sv);
        ent_t e;
        e.sv = sv;
        e.ca = {sv, 7'd0} ^ salt[12:0];
        e.p  = {4{salt ^ {26'd0, sv}}};
        e.l  = {4{~salt ^ {sv, 26'd0}}};
        return e;
    endfunction

    // From reset, the k-th result is the (k mod n)-th enabled slot in ascending order.
    function automatic ent_t exp_ent(input int k, input logic [NUM_SV-1:0] mask);
        int slots [$];
        for (int s = 0; s < NUM_SV; s++) begin
            if (mask[s]) slots.push_back(s);
        end
        return mk(tbl[slots[k % slots.size()]]);
    endfunction

    initial begin : core_model
        int         cnt;
        bit         cbusy;
        logic [5:0] csv;
        ent_t       e;
        cnt = 0; cbusy = 1'b0; csv = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                cbusy = 1'b0;
                codes_valid = 1'b1;
            end else if (!cbusy && gen_next && codes_valid) begin
                cbusy = 1'b1; cnt = gen_cycles; csv = sv_num; codes_valid = 1'b0;
            end else if (cbusy && !hang) begin
                if (cnt == 0) begin
                    e = mk(csv);
                    ca_code = e.ca; p_code = e.p; l_code = e.l;
                    codes_valid = 1'b1; cbusy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin : head_monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                e.sv = out_sv; e.ca = out_ca; e.p = out_p; e.l = out_l;
                got.push_back(e);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        run = 1'b0; out_ready = 1'b0; err_clr = 1'b0; hang = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        got.delete();
    endtask

    task automatic load_cfg(input logic [NUM_SV-1:0] mask);
        slot_en = mask;
        for (int s = 0; s < NUM_SV; s++) begin
            tbl[s] = 6'(s * 13 + int'($urandom_range(0, 12)));
            sv_table[6*s +: 6] = tbl[s];
        end
        salt = $urandom;
    endtask

    task automatic stop_and_drain();
        int n;
        run = 1'b0; out_ready = 1'b1; n = 0;
        while ((busy || out_valid) && n < 2000) begin tick(1); n++; end
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || gen_next !== 1'b0) begin errors++; $display("FAIL reset_ctl: busy=%b gen_next=%b required 0 0", busy, gen_next); end
        checks++; if (out_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: out_valid=%b err=%b required 0 0", out_valid, err); end
        checks++; if (sv_num !== 6'd0) begin errors++; $display("FAIL reset_sv_num: got %0d required 0", sv_num); end
        checks++; if ({out_sv, out_ca, out_p, out_l} !== '0) begin errors++; $display("FAIL reset_data: got sv=%0d ca=%h required all zero", out_sv, out_ca); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_no_slots();
        do_reset();
        load_cfg('0);
        run = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            checks++; if (busy !== 1'b0 || gen_next !== 1'b0) begin errors++; $display("FAIL no_slots c%0d: busy=%b gen_next=%b required 0 0", c, busy, gen_next); end
        end
        run = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [5:0] want [6];
        int         n;
        ent_t       e;
        do_reset();
        load_cfg(4'b1011);
        tbl[0] = 6'd3; tbl[1] = 6'd7; tbl[2] = 6'd12; tbl[3] = 6'd20;
        for (int s = 0; s < NUM_SV; s++) sv_table[6*s +: 6] = tbl[s];
        want[0] = 6'd3; want[1] = 6'd7; want[2] = 6'd20; want[3] = 6'd3; want[4] = 6'd7; want[5] = 6'd20;
        gen_cycles = 10; out_ready = 1'b1; run = 1'b1; n = 0;
        while (got.size() < 6 && n < 2000) begin tick(1); n++; end
        stop_and_drain();
        checks++; if (got.size() < 6) begin errors++; $display("FAIL rr_count: got %0d entries required at least 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i].sv !== want[i]) begin errors++; $display("FAIL rr_order%0d: sv=%0d required %0d", i, got[i].sv, want[i]); end
        end
        for (int i = 0; i < got.size(); i++) begin
            e = exp_ent(i, 4'b1011);
            checks++; if (got[i] !== e) begin errors++; $display("FAIL rr_entry%0d: got %h required %h", i, got[i], e); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_stop: busy=%b required 0", busy); end
    endtask

    task automatic test_random_rr();
        logic [NUM_SV-1:0] mask;
        int                n;
        int                want_n;
        ent_t              e;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            mask = NUM_SV'($urandom_range(1, (1 << NUM_SV) - 1));
            load_cfg(mask);
            gen_cycles = $urandom_range(1, 12);
            want_n = 2 * $countones(mask) + 1;
            run = 1'b1; n = 0;
            while (got.size() < want_n && n < 3000) begin
                out_ready = 1'($urandom_range(0, 1));
                tick(1); n++;
            end
            stop_and_drain();
            checks++; if (got.size() < want_n) begin errors++; $display("FAIL rand_count r%0d: got %0d required at least %0d", rep, got.size(), want_n); end
            for (int i = 0; i < got.size(); i++) begin
                e = exp_ent(i, mask);
                checks++; if (got[i] !== e) begin errors++; $display("FAIL rand_entry r%0d i%0d: got sv=%0d ca=%h required sv=%0d ca=%h", rep, i, got[i].sv, got[i].ca, e.sv, e.ca); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   n;
        ent_t e;
        do_reset();
        load_cfg(4'b1011);
        gen_cycles = 4; out_ready = 1'b0; run = 1'b1;
        tick(80);
        e = exp_ent(0, 4'b1011);
        checks++; if (out_valid !== 1'b1 || out_sv !== e.sv) begin errors++; $display("FAIL bp_head: valid=%b sv=%0d required 1 %0d", out_valid, out_sv, e.sv); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (gen_next !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold c%0d: gen_next=%b busy=%b required 0 1", c, gen_next, busy); end
            if (c < 3) tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        e = exp_ent(1, 4'b1011);
        checks++; if (out_sv !== e.sv || gen_next !== 1'b0) begin errors++; $display("FAIL bp_pop: sv=%0d gen_next=%b required %0d 0", out_sv, gen_next, e.sv); end
        tick(1);
        checks++; if (gen_next !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_push_wait: gen_next=%b valid=%b required 0 1", gen_next, out_valid); end
        tick(1);
        checks++; if (gen_next !== 1'b1) begin errors++; $display("FAIL bp_restart: gen_next=%b required 1", gen_next); end
        out_ready = 1'b1; n = 0;
        while (got.size() < 5 && n < 2000) begin tick(1); n++; end
        stop_and_drain();
        checks++; if (got.size() < 5) begin errors++; $display("FAIL bp_count: got %0d required at least 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            e = exp_ent(i, 4'b1011);
            checks++; if (got[i] !== e) begin errors++; $display("FAIL bp_entry%0d: got sv=%0d ca=%h required sv=%0d ca=%h", i, got[i].sv, got[i].ca, e.sv, e.ca); end
        end
    endtask

    task automatic test_run_stop();
        logic [NUM_SV-1:0] mask;
        int                n;
        bit                gen_seen;
        ent_t              e;
        do_reset();
        mask = NUM_SV'($urandom_range(1, (1 << NUM_SV) - 1));
        load_cfg(mask);
        gen_cycles = 6; out_ready = 1'b1; run = 1'b1; n = 0;
        while (gen_next !== 1'b1 && n < 200) begin tick(1); n++; end
        while (gen_next !== 1'b0 && n < 400) begin tick(1); n++; end
        checks++; if (gen_next !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stop_in_run: gen_next=%b busy=%b required 0 1", gen_next, busy); end
        run = 1'b0; gen_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (gen_next) gen_seen = 1'b1;
        end
        e = exp_ent(0, mask);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL stop_count: got %0d entries required 1", got.size()); end
        checks++; if (got.size() > 0 && got[0] !== e) begin errors++; $display("FAIL stop_entry: sv=%0d required %0d", got[0].sv, e.sv); end
        checks++; if (busy !== 1'b0 || gen_seen !== 1'b0) begin errors++; $display("FAIL stop_idle: busy=%b gen_seen=%b required 0 0", busy, gen_seen); end
    endtask

`ifdef GPS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        load_cfg(4'b1011);
        hang = 1'b1; out_ready = 1'b1; run = 1'b1; n = 0;
        while (gen_next !== 1'b1 && n < 200) begin tick(1); n++; end
        while (gen_next !== 1'b0 && n < 400) begin tick(1); n++; end
        n = 0;
        while (err !== 1'b1 && n < 100) begin tick(1); n++; end
        checks++; if (n != TIMEOUT) begin errors++; $display("FAIL to_cycles: err after %0d RUN cycles required %0d", n, TIMEOUT); end
        checks++; if (out_valid !== 1'b0 || got.size() != 0) begin errors++; $display("FAIL to_nopush: valid=%b entries=%0d required 0 0", out_valid, got.size()); end
        n = 0;
        while (gen_next !== 1'b1 && n < 50) begin tick(1); n++; end
        checks++; if (gen_next !== 1'b1 || sv_num !== tbl[1]) begin errors++; $display("FAIL to_next_slot: gen_next=%b sv=%0d required 1 %0d", gen_next, sv_num, tbl[1]); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_clear: err=%b required 0", err); end
        run = 1'b0;
    endtask
`else
    task automatic test_timeout();
        do_reset();
        load_cfg(4'b1011);
        hang = 1'b1; out_ready = 1'b1; run = 1'b1;
        tick(150);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_to_wait: err=%b busy=%b required 0 1", err, busy); end
        checks++; if (out_valid !== 1'b0 || gen_next !== 1'b0) begin errors++; $display("FAIL no_to_hold: valid=%b gen_next=%b required 0 0", out_valid, gen_next); end
        run = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        logic [NUM_SV-1:0] mask;
        int                n;
        do_reset();
        mask = NUM_SV'($urandom) | NUM_SV'(1) | NUM_SV'(1 << $urandom_range(1, NUM_SV - 1));
        load_cfg(mask);
        gen_cycles = 3; out_ready = 1'b0; run = 1'b1; n = 0;
        while (out_valid !== 1'b1 && n < 300) begin tick(1); n++; end
        while (gen_next !== 1'b1 && n < 600) begin tick(1); n++; end
        checks++; if (gen_next !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL ar_setup: gen_next=%b valid=%b required 1 1", gen_next, out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gen_next !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_immediate: gen_next=%b valid=%b busy=%b required 0 0 0", gen_next, out_valid, busy); end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (gen_next !== 1'b1 && n < 50) begin tick(1); n++; end
        checks++; if (gen_next !== 1'b1 || sv_num !== tbl[0]) begin errors++; $display("FAIL ar_first_slot: gen_next=%b sv=%0d required 1 %0d", gen_next, sv_num, tbl[0]); end
        stop_and_drain();
    endtask

    initial begin
        test_reset();
        test_no_slots();
        test_round_robin();
        test_random_rr();
        test_backpressure();
        test_run_stop();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
